pipe_ctrl: RTL and testbench

Central pipeline controller for the 5-stage core (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Collects per-stage stall requests and produces the 5-bit stalled vector consumed by every pipeline register. A register holds when its own bit is Stop; it inserts a bubble when its bit is Stop and the next bit is NoStop.
- Sequences control-flow redirects (branch, trap entry, mret). Trap and mret redirects wait for the memory stage to drain before the PC is redirected.
- Maintains a stall-cycle counter for performance monitoring.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_ctrl_sat_counter.sv | 33 +++
 rtl/pipe_ctrl.sv | 103 ++++++++++
 tb/tb_pipe_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall encodings, FSM states, reset level.
package pipe_ctrl_pkg;

  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;
  localparam logic RstEnable = 1'b0;

  // Bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB
  localparam logic [4:0] STALL_NONE = 5'b00000;
  localparam logic [4:0] STALL_IF   = 5'b00001;
  localparam logic [4:0] STALL_ID   = 5'b00011;
  localparam logic [4:0] STALL_EX   = 5'b00111;
  localparam logic [4:0] STALL_MEM  = 5'b01111;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall vector, branch/trap/mret redirect sequencing, stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_W = 5,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if_i,
  input  logic               stallreq_id_i,
  input  logic               stallreq_ex_i,
  input  logic               stallreq_mem_i,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_addr_i,
  input  logic               trap_req_i,
  input  logic [ADDR_W-1:0]  trap_vec_i,
  input  logic               mret_req_i,
  input  logic [ADDR_W-1:0]  mepc_i,
  output logic [STALL_W-1:0] stalled_o,
  output logic               flush_o,
  output logic [ADDR_W-1:0]  flush_addr_o,
  output logic               trap_ack_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  state_e state_q, state_d;
  logic   trap_src_q, trap_src_d;
  logic [STALL_W-1:0] req_stall;

  // Higher pipeline stage always wins.
  always_comb begin
    req_stall = STALL_NONE;
    if (stallreq_mem_i) begin
      req_stall = STALL_MEM;
    end else if (stallreq_ex_i) begin
      req_stall = STALL_EX;
    end else if (stallreq_id_i) begin
      req_stall = STALL_ID;
    end else if (stallreq_if_i) begin
      req_stall = STALL_IF;
    end
  end

  always_comb begin
    state_d      = state_q;
    trap_src_d   = trap_src_q;
    stalled_o    = STALL_NONE;
    flush_o      = 1'b0;
    flush_addr_o = '0;
    trap_ack_o   = 1'b0;
    case (state_q)
      RUN: begin
        stalled_o = req_stall;
        // A trap/mret kills any same-cycle branch; trap wins over mret.
        if (trap_req_i || mret_req_i) begin
          trap_src_d = trap_req_i;
          state_d    = stallreq_mem_i ? DRAIN : REDIRECT;
        end else if (branch_flag_i && !stallreq_ex_i && !stallreq_mem_i) begin
          flush_o      = 1'b1;
          flush_addr_o = branch_addr_i;
          stalled_o    = STALL_NONE;
        end
      end
      DRAIN: begin
        stalled_o = stallreq_mem_i ? STALL_MEM : STALL_EX;
        if (!stallreq_mem_i) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        flush_o      = 1'b1;
        trap_ack_o   = 1'b1;
        flush_addr_o = trap_src_q ? trap_vec_i : mepc_i;
        state_d      = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state_q    <= RUN;
      trap_src_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      trap_src_q <= trap_src_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .en_i (|stalled_o),
    .cnt_o(stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; a second 3-bit-counter instance exercises saturation.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic        branch_flag_i;
  logic [31:0] branch_addr_i;
  logic        trap_req_i;
  logic [31:0] trap_vec_i;
  logic        mret_req_i;
  logic [31:0] mepc_i;
  logic [4:0]  stalled_o;
  logic        flush_o;
  logic [31:0] flush_addr_o;
  logic        trap_ack_o;
  logic [31:0] stall_cnt_o;
  logic [4:0]  s_stalled;
  logic        s_flush;
  logic [31:0] s_flush_addr;
  logic        s_ack;
  logic [2:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_if_i(stallreq_if_i), .stallreq_id_i(stallreq_id_i),
    .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i),
    .branch_flag_i(branch_flag_i), .branch_addr_i(branch_addr_i),
    .trap_req_i(trap_req_i), .trap_vec_i(trap_vec_i),
    .mret_req_i(mret_req_i), .mepc_i(mepc_i),
    .stalled_o(stalled_o), .flush_o(flush_o), .flush_addr_o(flush_addr_o),
    .trap_ack_o(trap_ack_o), .stall_cnt_o(stall_cnt_o)
  );

  pipe_ctrl #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst),
    .stallreq_if_i(stallreq_if_i), .stallreq_id_i(stallreq_id_i),
    .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i),
    .branch_flag_i(branch_flag_i), .branch_addr_i(branch_addr_i),
    .trap_req_i(trap_req_i), .trap_vec_i(trap_vec_i),
    .mret_req_i(mret_req_i), .mepc_i(mepc_i),
    .stalled_o(s_stalled), .flush_o(s_flush), .flush_addr_o(s_flush_addr),
    .trap_ack_o(s_ack), .stall_cnt_o(s_cnt)
  );

  task automatic drive_idle();
    stallreq_if_i = 0; stallreq_id_i = 0; stallreq_ex_i = 0; stallreq_mem_i = 0;
    branch_flag_i = 0; branch_addr_i = '0; trap_req_i = 0; trap_vec_i = '0;
    mret_req_i = 0; mepc_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    #2;
    checks++; if (stalled_o !== 5'b00000) begin errors++; $display("[TB] FAIL rst_stalled: got %b want 00000", stalled_o); end
    checks++; if (flush_o !== 1'b0 || trap_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_flush_ack: got %b/%b want 0/0", flush_o, trap_ack_o); end
    checks++; if (flush_addr_o !== 32'h0 || stall_cnt_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr_cnt: got %h/%0d want 0/0", flush_addr_o, stall_cnt_o); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (stalled_o !== 5'b00000 || stall_cnt_o !== 32'd0) begin errors++; $display("[TB] FAIL rst_release: stalled %b cnt %0d want 00000/0", stalled_o, stall_cnt_o); end
  endtask

  task automatic test_stall_priority();
    @(negedge clk); stallreq_id_i = 1; #1;
    checks++; if (stalled_o !== 5'b00011) begin errors++; $display("[TB] FAIL prio_id: got %b want 00011", stalled_o); end
    @(negedge clk); stallreq_mem_i = 1; #1;
    checks++; if (stalled_o !== 5'b01111) begin errors++; $display("[TB] FAIL prio_id_mem: got %b want 01111", stalled_o); end
    @(negedge clk); stallreq_id_i = 0; stallreq_mem_i = 0; stallreq_ex_i = 1; #1;
    checks++; if (stalled_o !== 5'b00111) begin errors++; $display("[TB] FAIL prio_ex: got %b want 00111", stalled_o); end
    @(negedge clk); stallreq_ex_i = 0; stallreq_if_i = 1; #1;
    checks++; if (stalled_o !== 5'b00001) begin errors++; $display("[TB] FAIL prio_if: got %b want 00001", stalled_o); end
    @(negedge clk); stallreq_if_i = 0; #1;
    checks++; if (stalled_o !== 5'b00000) begin errors++; $display("[TB] FAIL prio_none: got %b want 00000", stalled_o); end
    checks++; if (stall_cnt_o !== 32'd4) begin errors++; $display("[TB] FAIL cnt_after_prio: got %0d want 4", stall_cnt_o); end
    checks++; if (s_cnt !== 3'd4) begin errors++; $display("[TB] FAIL small_cnt_after_prio: got %0d want 4", s_cnt); end
  endtask

  task automatic test_branch();
    @(negedge clk); branch_flag_i = 1; branch_addr_i = 32'h8000_0100; #1;
    checks++; if (flush_o !== 1'b1 || flush_addr_o !== 32'h8000_0100 || stalled_o !== 5'b0) begin errors++; $display("[TB] FAIL branch_flush: got %b %h %b want 1 80000100 00000", flush_o, flush_addr_o, stalled_o); end
    @(negedge clk); stallreq_id_i = 1; #1;
    checks++; if (flush_o !== 1'b1 || stalled_o !== 5'b0) begin errors++; $display("[TB] FAIL branch_over_id: got %b %b want 1 00000", flush_o, stalled_o); end
    @(negedge clk); stallreq_id_i = 0; stallreq_ex_i = 1; #1;
    checks++; if (flush_o !== 1'b0 || stalled_o !== 5'b00111 || trap_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL branch_ex_defer: got %b %b %b want 0 00111 0", flush_o, stalled_o, trap_ack_o); end
    @(negedge clk); #1;
    checks++; if (flush_o !== 1'b0) begin errors++; $display("[TB] FAIL branch_ex_defer2: got %b want 0", flush_o); end
    @(negedge clk); stallreq_ex_i = 0; #1;
    checks++; if (flush_o !== 1'b1 || flush_addr_o !== 32'h8000_0100) begin errors++; $display("[TB] FAIL branch_release: got %b %h want 1 80000100", flush_o, flush_addr_o); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (flush_o !== 1'b0 || stall_cnt_o !== 32'd6) begin errors++; $display("[TB] FAIL branch_done: flush %b cnt %0d want 0/6", flush_o, stall_cnt_o); end
  endtask

  task automatic test_trap_drain();
    @(negedge clk); trap_req_i = 1; trap_vec_i = 32'h8000_0004; stallreq_mem_i = 1; #1;
    checks++; if (stalled_o !== 5'b01111 || flush_o !== 1'b0 || trap_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL trap_enter: got %b %b %b want 01111 0 0", stalled_o, flush_o, trap_ack_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); branch_flag_i = 1; branch_addr_i = 32'h8000_0500; #1;
      checks++; if (stalled_o !== 5'b01111 || flush_o !== 1'b0 || trap_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL drain_mem%0d: got %b %b %b want 01111 0 0", i, stalled_o, flush_o, trap_ack_o); end
    end
    @(negedge clk); stallreq_mem_i = 0; #1;
    checks++; if (stalled_o !== 5'b00111 || flush_o !== 1'b0 || trap_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL drain_last: got %b %b %b want 00111 0 0", stalled_o, flush_o, trap_ack_o); end
    @(negedge clk); branch_flag_i = 0; #1;
    checks++; if (flush_o !== 1'b1 || trap_ack_o !== 1'b1 || flush_addr_o !== 32'h8000_0004 || stalled_o !== 5'b0) begin errors++; $display("[TB] FAIL trap_redirect: got %b %b %h %b want 1 1 80000004 00000", flush_o, trap_ack_o, flush_addr_o, stalled_o); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (flush_o !== 1'b0 || trap_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL trap_after: got %b %b want 0 0", flush_o, trap_ack_o); end
    checks++; if (stall_cnt_o !== 32'd11) begin errors++; $display("[TB] FAIL cnt_after_trap: got %0d want 11", stall_cnt_o); end
    checks++; if (s_cnt !== 3'd7) begin errors++; $display("[TB] FAIL small_cnt_saturate: got %0d want 7", s_cnt); end
  endtask

  task automatic test_mret();
    @(negedge clk); mret_req_i = 1; mepc_i = 32'h8000_0200; #1;
    checks++; if (flush_o !== 1'b0 || trap_ack_o !== 1'b0 || stalled_o !== 5'b0) begin errors++; $display("[TB] FAIL mret_req: got %b %b %b want 0 0 00000", flush_o, trap_ack_o, stalled_o); end
    @(negedge clk); #1;
    checks++; if (flush_o !== 1'b1 || trap_ack_o !== 1'b1 || flush_addr_o !== 32'h8000_0200) begin errors++; $display("[TB] FAIL mret_redirect: got %b %b %h want 1 1 80000200", flush_o, trap_ack_o, flush_addr_o); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (flush_o !== 1'b0 || trap_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL mret_after: got %b %b want 0 0", flush_o, trap_ack_o); end
  endtask

  task automatic test_collision();
    @(negedge clk); trap_req_i = 1; trap_vec_i = 32'h8000_0040; branch_flag_i = 1; branch_addr_i = 32'h8000_0500; #1;
    checks++; if (flush_o !== 1'b0) begin errors++; $display("[TB] FAIL coll_no_branch: got %b want 0", flush_o); end
    @(negedge clk); branch_flag_i = 0; #1;
    checks++; if (flush_o !== 1'b1 || flush_addr_o !== 32'h8000_0040 || trap_ack_o !== 1'b1) begin errors++; $display("[TB] FAIL coll_trap: got %b %h %b want 1 80000040 1", flush_o, flush_addr_o, trap_ack_o); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (flush_o !== 1'b0) begin errors++; $display("[TB] FAIL coll_after: got %b want 0", flush_o); end
    @(negedge clk); trap_req_i = 1; mret_req_i = 1; trap_vec_i = 32'h8000_0080; mepc_i = 32'h8000_0300; #1;
    checks++; if (flush_o !== 1'b0) begin errors++; $display("[TB] FAIL both_req: got %b want 0", flush_o); end
    @(negedge clk); #1;
    checks++; if (flush_o !== 1'b1 || flush_addr_o !== 32'h8000_0080) begin errors++; $display("[TB] FAIL both_trap_wins: got %b %h want 1 80000080", flush_o, flush_addr_o); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (flush_o !== 1'b0 || stall_cnt_o !== 32'd11) begin errors++; $display("[TB] FAIL both_after: flush %b cnt %0d want 0/11", flush_o, stall_cnt_o); end
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk); trap_req_i = 1; trap_vec_i = 32'h8000_0004; stallreq_mem_i = 1; #1;
    @(negedge clk); #1;
    checks++; if (stalled_o !== 5'b01111 || flush_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_drain: got %b %b want 01111 0", stalled_o, flush_o); end
    rst = 1'b0; drive_idle(); #1;
    checks++; if (stalled_o !== 5'b0 || flush_o !== 1'b0 || trap_ack_o !== 1'b0 || stall_cnt_o !== 32'd0 || flush_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL drain_rst: got %b %b %b %0d %h want all 0", stalled_o, flush_o, trap_ack_o, stall_cnt_o, flush_addr_o); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (stalled_o !== 5'b0 || flush_o !== 1'b0 || trap_ack_o !== 1'b0 || stall_cnt_o !== 32'd0) begin errors++; $display("[TB] FAIL post_rst%0d: got %b %b %b %0d want 00000 0 0 0", i, stalled_o, flush_o, trap_ack_o, stall_cnt_o); end
      @(negedge clk);
    end
  endtask

  initial begin
    $display("[TB] pipe_ctrl directed test start");
    test_reset();
    test_stall_priority();
    test_branch();
    test_trap_drain();
    test_mret();
    test_collision();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
